// File: rtl/exu_alu_ctrl.sv
// exu_alu_ctrl: execute-stage controller that feeds a combinational ALU and hands results to writeback
// Ports:
//   clk, rst (sync active-high), flush (sync kill of in-flight op)
//   in_*    : decoded op from IDU over valid/ready (in_ready combinational)
//   alu_*   : registered operands/choice to ALU, res/overflow back from it
//   out_*   : result to WBU over valid/ready, held stable until accepted
//   retired : count of completed out handshakes
module exu_alu_ctrl #(
    parameter int BW  = 32,
    parameter int SHW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_src1,
    input  logic [BW-1:0] in_src2,
    input  logic [BW-1:0] in_imm,
    input  logic [BW-1:0] in_pc,
    input  logic          in_sel1,
    input  logic          in_sel2,
    input  logic [3:0]    in_op,
    input  logic          in_neg,
    input  logic [4:0]    in_rd,
    input  logic          in_wen,
    output logic [BW-1:0] alu_d1,
    output logic [BW-1:0] alu_d2,
    output logic [3:0]    alu_choice,
    input  logic [BW-1:0] alu_res,
    input  logic          alu_of,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_res,
    output logic          out_of,
    output logic [4:0]    out_rd,
    output logic          out_wen,
    output logic [31:0]   retired
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic          neg_q;
    logic [4:0]    rd_q;
    logic          wen_q;
    logic          accept;
    logic          in_shift;
    logic          cur_cmp;
    logic          cur_arith;
    logic [BW-1:0] d2_raw;
    logic [BW-1:0] d2_cond;

    assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_shift  = in_op == ALU_SLL || in_op == ALU_SRL || in_op == ALU_SRA;
        d2_raw    = in_sel2 ? in_imm : in_src2;
        // shifters only look at the low SHW bits; clear the rest so the ALU sees a clean amount
        d2_cond   = in_shift ? {{(BW-SHW){1'b0}}, d2_raw[SHW-1:0]} : d2_raw;
        cur_cmp   = alu_choice == ALU_SLT || alu_choice == ALU_SLTU || alu_choice == ALU_EQ;
        cur_arith = alu_choice == ALU_ADD || alu_choice == ALU_SUB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_d1     <= '0;
            alu_d2     <= '0;
            alu_choice <= '0;
            neg_q      <= 1'b0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_of     <= 1'b0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
            retired    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    out_res   <= cur_cmp ? {{(BW-1){1'b0}}, alu_res[0] ^ neg_q} : alu_res;
                    out_of    <= cur_arith && alu_of;
                    out_rd    <= rd_q;
                    out_wen   <= wen_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        retired   <= retired + 32'd1;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // accept can only happen from IDLE or a completing DONE, so it overrides the IDLE target
            if (accept) begin
                alu_d1     <= in_sel1 ? in_pc : in_src1;
                alu_d2     <= d2_cond;
                alu_choice <= in_op;
                neg_q      <= in_neg;
                rd_q       <= in_rd;
                wen_q      <= in_wen;
                state      <= EXEC;
            end
        end
    end
endmodule

// File: tb/tb_exu_alu_ctrl.sv
// tb_exu_alu_ctrl: randomized scoreboard bench for exu_alu_ctrl with a behavioural ALU and reference model
module tb_exu_alu_ctrl;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                           SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9, EQ = 4'd10;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [31:0] in_src1 = '0, in_src2 = '0, in_imm = '0, in_pc = '0;
    logic in_sel1 = 1'b0, in_sel2 = 1'b0, in_neg = 1'b0, in_wen = 1'b0;
    logic [3:0] in_op = '0;
    logic [4:0] in_rd = '0;
    logic [31:0] alu_d1, alu_d2, alu_res, out_res, retired;
    logic [3:0] alu_choice;
    logic alu_of, out_valid, out_ready = 1'b0, out_of, out_wen;
    logic [4:0] out_rd;

    int checks = 0, failures = 0;
    bit rnd = 1'b0;

    typedef struct {
        logic [31:0] d1, d2, res;
        logic [3:0]  op;
        logic        of, wen;
        logic [4:0]  rd;
        int          age;
    } exp_t;
    exp_t q[$];
    logic [31:0] exp_ret = '0;

    exu_alu_ctrl #(.BW(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm), .in_pc(in_pc),
        .in_sel1(in_sel1), .in_sel2(in_sel2), .in_op(in_op), .in_neg(in_neg),
        .in_rd(in_rd), .in_wen(in_wen), .alu_d1(alu_d1), .alu_d2(alu_d2),
        .alu_choice(alu_choice), .alu_res(alu_res), .alu_of(alu_of),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_of(out_of),
        .out_rd(out_rd), .out_wen(out_wen), .retired(retired)
    );

    always #5 clk = ~clk;

    // stand-in ALU: compares put junk in the upper bits and overflow is noisy on non-arith ops
    always_comb begin
        logic [31:0] s;
        s = '0;
        alu_of = ^(alu_d1 ^ alu_d2);
        case (alu_choice)
            ADD: begin s = alu_d1 + alu_d2; alu_of = (alu_d1[31] == alu_d2[31]) && (s[31] != alu_d1[31]); end
            SUB: begin s = alu_d1 - alu_d2; alu_of = (alu_d1[31] != alu_d2[31]) && (s[31] != alu_d1[31]); end
            AND_: s = alu_d1 & alu_d2;
            OR_: s = alu_d1 | alu_d2;
            XOR_: s = alu_d1 ^ alu_d2;
            SLL: s = alu_d1 << alu_d2;
            SRL: s = alu_d1 >> alu_d2;
            SRA: s = $signed(alu_d1) >>> alu_d2;
            SLT: s = {alu_d1[31:1], $signed(alu_d1) < $signed(alu_d2)};
            SLTU: s = {alu_d1[31:1], alu_d1 < alu_d2};
            EQ: s = {alu_d1[31:1], alu_d1 != alu_d2};
            default: s = '0;
        endcase
        alu_res = s;
    end

    function automatic exp_t model(logic [3:0] op, logic [31:0] s1, s2, imm, pc,
                                   logic sel1, sel2, neg, logic [4:0] rd, logic wen);
        exp_t e;
        logic [31:0] a, b;
        longint sa, sb, t;
        int unsigned sh;
        a = sel1 ? pc : s1;
        b = sel2 ? imm : s2;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b % 32;
        e.d1 = a; e.d2 = b; e.op = op; e.rd = rd; e.wen = wen; e.of = 1'b0; e.age = 0; e.res = '0;
        case (op)
            ADD: begin t = sa + sb; e.res = a + b; e.of = t > 64'sd2147483647 || t < -64'sd2147483648; end
            SUB: begin t = sa - sb; e.res = a - b; e.of = t > 64'sd2147483647 || t < -64'sd2147483648; end
            AND_: e.res = a & b;
            OR_: e.res = a | b;
            XOR_: e.res = a ^ b;
            SLL: begin e.d2 = sh; e.res = a << sh; end
            SRL: begin e.d2 = sh; e.res = a >> sh; end
            SRA: begin e.d2 = sh; t = sa >>> sh; e.res = t[31:0]; end
            SLT: e.res = {31'b0, (sa < sb) ^ neg};
            SLTU: e.res = {31'b0, (a < b) ^ neg};
            EQ: e.res = {31'b0, (a != b) ^ neg};
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            q.delete();
            exp_ret = '0;
        end else begin
            if (q.size() > 0) q[0].age = q[0].age + 1;
            ev = q.size() > 0 && q[0].age >= 2;
            chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
            chk("in_ready", {31'b0, in_ready}, {31'b0, !flush && (q.size() == 0 || (ev && out_ready))});
            chk("retired", retired, exp_ret);
            if (q.size() > 0 && q[0].age == 1) begin
                chk("alu_d1", alu_d1, q[0].d1);
                chk("alu_d2", alu_d2, q[0].d2);
                chk("alu_choice", {28'b0, alu_choice}, {28'b0, q[0].op});
            end
            if (ev) begin
                chk("out_res", out_res, q[0].res);
                chk("out_of", {31'b0, out_of}, {31'b0, q[0].of});
                chk("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
                chk("out_wen", {31'b0, out_wen}, {31'b0, q[0].wen});
            end
            if (flush) q.delete();
            else begin
                if (ev && out_ready) begin
                    void'(q.pop_front());
                    exp_ret = exp_ret + 32'd1;
                end
                if (in_valid && in_ready)
                    q.push_back(model(in_op, in_src1, in_src2, in_imm, in_pc, in_sel1, in_sel2,
                                      in_neg, in_rd, in_wen));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 40) == 0;
        end
    endtask

    task automatic send(logic [3:0] op, logic [31:0] s1, s2, imm, pc, logic sel1, sel2, neg);
        bit ok;
        ok = 1'b0;
        in_op = op; in_src1 = s1; in_src2 = s2; in_imm = imm; in_pc = pc;
        in_sel1 = sel1; in_sel2 = sel2; in_neg = neg;
        in_rd = 5'($urandom); in_wen = 1'($urandom);
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1;
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=not_accepted expected=accepted");
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        idle(2);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_alu_d1", alu_d1, 32'd0);
        chk("rst_alu_d2", alu_d2, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send(ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("lat_exec_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lat_done_valid", {31'b0, out_valid}, 32'd1);
        chk("add_res", out_res, 32'd12);
        idle(2);
        chk("add_retired", retired, 32'd1);
        send(ADD, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        send(SRA, 32'h8000_0000, 32'hFFFF_FF24, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("sra_d2", alu_d2, 32'd4);
        idle(3);
        send(EQ, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        send(EQ, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(3);
        send(ADD, 32'd0, 32'd0, 32'd0, 32'h8000_0010, 1'b1, 1'b1, 1'b0);
        idle(3);
        out_ready = 1'b0;
        send(XOR_, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(6);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        send(SUB, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        send(OR_, 32'hF0, 32'h0F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_exec_valid", {31'b0, out_valid}, 32'd0);
        idle(1);
        out_ready = 1'b0;
        send(AND_, 32'hFF, 32'h0F, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done_valid", {31'b0, out_valid}, 32'd0);
        idle(2);
        rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom_range(0, 3) == 0 ? a : $urandom;
            send(4'($urandom_range(0, 10)), a, b, $urandom, $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drain_queue", q.size(), 32'd0);
        out_ready = 1'b0;
        send(ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_retired", retired, 32'd0);
        chk("midrst_d1", alu_d1, 32'd0);
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
